// File: rtl/booth_mult_seq.sv
// booth_mult_seq: multi-cycle radix-2 Booth multiplier for the calculator datapath.
// It performs one add/subtract plus arithmetic shift per clock. It accepts a new
// operand pair from IDLE on start and then holds the last product until the next
// completion.
module booth_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [WIDTH+1:0]   acc;      // A: two guard bits so +/-M never overflows
    logic [WIDTH:0]     mcand;    // M
    logic [WIDTH:0]     mplier;   // Q
    logic               q_1;
    logic [CNT_W-1:0]   count;

    // The operands get one extra bit. This lets a single signed Booth datapath
    // cover both modes: the extra bit is a sign extension when signed_mode=1 and
    // a zero extension when signed_mode=0.
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    assign a_ext = {signed_mode & a[WIDTH-1], a};
    assign b_ext = {signed_mode & b[WIDTH-1], b};

    logic [WIDTH+1:0]   m_sext;
    assign m_sext = {mcand[WIDTH], mcand};

    logic [WIDTH+1:0]   sum;
    logic [WIDTH+1:0]   acc_nxt;
    logic [WIDTH:0]     mplier_nxt;
    logic               q_1_nxt;

    // One Booth step: conditional add/subtract of M, followed by an arithmetic
    // right shift of {A,Q,q_1}.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        sum = acc;
        case ({mplier[0], q_1})
            2'b01:   sum = acc + m_sext;
            2'b10:   sum = acc - m_sext;
            default: sum = acc;
        endcase
        acc_nxt    = {sum[WIDTH+1], sum[WIDTH+1:1]};
        mplier_nxt = {sum[0], mplier[WIDTH:1]};
        q_1_nxt    = mplier[0];
    end

    // Control FSM and datapath registers, with registered busy/done/product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values, whatever the statement order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_ext;
                        mplier <= b_ext;
                        acc    <= '0;
                        q_1    <= 1'b0;
                        count  <= CNT_W'(WIDTH + 1);
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier_nxt;
                    q_1    <= q_1_nxt;
                    count  <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        // After WIDTH+1 steps the full product sits in the low bits of {A,Q}.
                        product <= {acc_nxt[WIDTH-2:0], mplier_nxt};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed checks on the 8-bit multiplier, plus a random sweep
// of the 4-bit and 12-bit variants against a reference multiply.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic        start = 1'b0, sm = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        busy, done;
    logic [15:0] product;

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(sm),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    // WIDTH=4 instance
    logic        s4_start = 1'b0, s4_sm = 1'b0;
    logic [3:0]  s4_a = '0, s4_b = '0;
    logic        s4_busy, s4_done;
    logic [7:0]  s4_prod;

    booth_mult_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .signed_mode(s4_sm),
        .a(s4_a), .b(s4_b), .busy(s4_busy), .done(s4_done), .product(s4_prod)
    );

    // WIDTH=12 instance
    logic        s12_start = 1'b0, s12_sm = 1'b0;
    logic [11:0] s12_a = '0, s12_b = '0;
    logic        s12_busy, s12_done;
    logic [23:0] s12_prod;

    booth_mult_seq #(.WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .start(s12_start), .signed_mode(s12_sm),
        .a(s12_a), .b(s12_b), .busy(s12_busy), .done(s12_done), .product(s12_prod)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle, so that outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the WIDTH=8 done pulse. Check the latency from the current
    // sample, the number of busy cycles and the product.
    task automatic wait_done(input int exp_lat, input logic [15:0] exp_p, input string tag);
        int n  = 0;
        int bc = (busy === 1'b1) ? 1 : 0;
        while (n < 40) begin
            step();
            n++;
            if (done === 1'b1) break;
            if (busy === 1'b1) bc++;
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_busycnt"}, bc, exp_lat);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check({tag, "_prod"}, {16'b0, product}, {16'b0, exp_p});
    endtask

    // Single operation on the WIDTH=8 instance, started from IDLE.
    task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] exp_p, input string tag);
        sm = s; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_acc"}, {31'b0, busy}, 32'd1);
        wait_done(9, exp_p, tag);
        step();
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    function automatic logic [31:0] ref_mul(input int w, input logic s,
                                            input logic [15:0] x, input logic [15:0] y);
        longint xv, yv, p;
        xv = longint'(x);
        yv = longint'(y);
        if (s && x[w-1]) xv = xv - (longint'(1) << w);
        if (s && y[w-1]) yv = yv - (longint'(1) << w);
        p = xv * yv;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    task automatic sweep(input int w, input int n_ops);
        logic [15:0] ra, rb;
        logic        rs;
        logic [31:0] pr;
        logic        dn;
        int          lat;
        for (int i = 0; i < n_ops; i++) begin
            ra = 16'($urandom) & 16'((1 << w) - 1);
            rb = 16'($urandom) & 16'((1 << w) - 1);
            rs = 1'($urandom_range(0, 1));
            if (w == 4) begin
                s4_a = ra[3:0]; s4_b = rb[3:0]; s4_sm = rs; s4_start = 1'b1;
            end else begin
                s12_a = ra[11:0]; s12_b = rb[11:0]; s12_sm = rs; s12_start = 1'b1;
            end
            step();
            s4_start  = 1'b0;
            s12_start = 1'b0;
            lat = 0;
            dn  = 1'b0;
            while (lat < 40 && dn !== 1'b1) begin
                step();
                lat++;
                dn = (w == 4) ? s4_done : s12_done;
            end
            pr = (w == 4) ? {24'b0, s4_prod} : {8'b0, s12_prod};
            check("sweep_lat", lat, w + 1);
            check("sweep_prod", pr, ref_mul(w, rs, ra, rb));
            step();  // back in IDLE before the next op
        end
    endtask

    initial begin
        int dn_cnt;

        // Reset state
        #2;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_prod", {16'b0, product}, 32'd0);
        step();
        step();
        #2 rst = 1'b1;
        step();
        check("post_rst_prod", {16'b0, product}, 32'd0);
        check("post_rst_busy", {31'b0, busy}, 32'd0);

        // Basic signed/unsigned vectors, including the most-negative corner cases
        op8(1'b1, 8'h07, 8'hFD, 16'hFFEB, "s7xm3");
        op8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "uFFxFF");
        op8(1'b1, 8'hFF, 8'hFF, 16'h0001, "sFFxFF");
        op8(1'b1, 8'h80, 8'h80, 16'h4000, "s80x80");
        op8(1'b1, 8'h80, 8'h7F, 16'hC080, "s80x7F");
        op8(1'b0, 8'h0C, 8'h0A, 16'h0078, "u12x10");

        // start held high: each completion is followed by an accept on the done cycle
        sm = 1'b0; a = 8'd3; b = 8'd5; start = 1'b1;
        step();
        check("hold_acc0", {31'b0, busy}, 32'd1);
        wait_done(9, 16'd15, "hold_r0");
        step();
        check("hold_done1cyc0", {31'b0, done}, 32'd0);
        check("hold_acc1", {31'b0, busy}, 32'd1);
        wait_done(9, 16'd15, "hold_r1");
        step();
        check("hold_done1cyc1", {31'b0, done}, 32'd0);
        check("hold_acc2", {31'b0, busy}, 32'd1);
        a = 8'd2; b = 8'd2;  // changed mid-RUN, so this run must still produce 15
        wait_done(9, 16'd15, "hold_r2");
        step();
        start = 1'b0;
        check("hold_done1cyc2", {31'b0, done}, 32'd0);
        check("hold_acc3", {31'b0, busy}, 32'd1);
        wait_done(9, 16'd4, "hold_r3");
        step();
        check("hold_done1cyc3", {31'b0, done}, 32'd0);
        check("hold_idle", {31'b0, busy}, 32'd0);

        // Reset asserted in RUN cycle 4 aborts the op and clears the product at once
        sm = 1'b0; a = 8'd100; b = 8'd100; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        check("abort_busy_pre", {31'b0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_prod", {16'b0, product}, 32'd0);
        dn_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done !== 1'b0) dn_cnt++;
        end
        check("abort_no_done", dn_cnt, 0);
        #2 rst = 1'b1;
        step();
        op8(1'b0, 8'h00, 8'h55, 16'h0000, "after_abort");

        // Random sweep on the narrow and wide variants
        sweep(4, 1000);
        sweep(12, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised, multi-cycle radix-2 Booth multiplier for the keypad/7-segment calculator datapath. It sits between the operand-entry logic and the binary-to-BCD/display path. It is the generalised successor of the fixed 12-bit accumulate path, adding:
- configurable operand width
- runtime signed/unsigned mode
- a start/busy/done handshake
- a held product register

Parameters:
WIDTH, 8, operand width in bits (legal range 2..16); product width is 2*WIDTH.
CNT_W, $clog2(WIDTH+2), iteration counter width; derived, do not override.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request a multiply; sampled only in IDLE
signed_mode  input  1  1 = operands are two's complement; 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  single-cycle pulse; product is valid from this cycle on
product  output  2*WIDTH  last completed result, held until the next completion

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0, done=0, product=0.
  - All internal registers (A, Q, q_1, M, count) cleared.
  - Reset asserted mid-RUN aborts the operation; no done pulse follows; product stays 0.
- Internal widths:
  - M, Q: WIDTH+1 bits. Operands are sign-extended when signed_mode=1, zero-extended when 0.
  - A: WIDTH+2 bits, so M = most-negative or 2^WIDTH-1 cannot overflow on add/subtract.
  - q_1: 1 bit.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at a rising edge:
    - M<=ext(a), Q<=ext(b), A<=0, q_1<=0, count<=WIDTH+1, state<=RUN.
  - busy goes high in the following cycle. Otherwise hold all registers.
- RUN, each cycle performs one Booth step:
  - {Q[0],q_1}=01: A<=A+sext(M).
  - {Q[0],q_1}=10: A<=A-sext(M).
  - 00/11: no add.
  - Then arithmetic right shift of the concatenation {A,Q,q_1} by 1, with the MSB of A replicated. Add and shift are combined in one cycle.
  - count<=count-1.
- Completion, on the RUN step where count==1:
  - product<=low 2*WIDTH bits of the post-shift {A,Q}.
  - done<=1; state<=IDLE.
- Latency: start sampled at edge k gives busy=1 for cycles k+1..k+WIDTH+1. done=1 and product valid in the cycle after edge k+WIDTH+1, i.e. exactly WIDTH+1 clocks after the accepting edge.
- done is a registered 1-cycle pulse, deasserted on the next edge unconditionally.
- start while busy=1 is ignored (no queuing); a, b and signed_mode changes during RUN have no effect.
- start in the same cycle done=1 (state is already IDLE) is accepted; back-to-back throughput is one result per WIDTH+1 cycles.
- Result rules:
  - signed_mode=0: product equals the exact unsigned product (max (2^W-1)^2 fits in 2W bits).
  - signed_mode=1: product equals the exact two's-complement product, including (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
- product is never X after reset. It changes only on a completion edge or on reset.

Test Plan:
- WIDTH=8, signed_mode=1, a=0x07 (7), b=0xFD (-3), start 1 cycle -> busy high 9 cycles; done pulse 9 clocks after the accepting edge; product=0xFFEB (-21).
- WIDTH=8, signed_mode=0, a=0xFF, b=0xFF -> product=0xFE01 (65025); repeat with signed_mode=1 and the same bits -> product=0x0001.
- WIDTH=8, signed_mode=1, a=0x80, b=0x80 -> product=0x4000. Then a=0x80, b=0x7F -> product=0xC080 (-16256).
- Hold start high continuously, a=3, b=5 -> results complete every 9 cycles, each product=15. A new a=2, b=2 presented mid-RUN is ignored until the next accept. done never exceeds 1 cycle.
- Start a=100, b=100 (unsigned); pull rst low at RUN cycle 4 -> busy=0, done=0, product=0 immediately (async). After release, a new start a=0, b=0x55 -> product=0.
- Random sweep, WIDTH=4 and WIDTH=12, all modes, 2000 ops -> product matches the reference multiply; latency always WIDTH+1.
